// File: rtl/serial_sub5_if.sv
// Start/done handshake and operand/result bus for the bit-serial 5-bit subtractor.
interface serial_sub5_if;
    logic       start;
    logic [4:0] a;
    logic [4:0] b;
    logic [5:0] diff;
    logic       busy;
    logic       done;

    modport master (output start, a, b, input diff, busy, done);
    modport slave  (input start, a, b, output diff, busy, done);
endinterface

// File: rtl/serial_sub5.sv
// Bit-serial a - b, LSB first, one full-subtractor cell plus a borrow flop;
// 6-bit two's-complement result published once per operation.
module serial_sub5 (
    input  logic          clk,
    input  logic          reset,
    serial_sub5_if.slave  bus
);
    localparam int unsigned OP_W  = 5;
    localparam int unsigned RES_W = 6;
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_nx;
    logic [OP_W-1:0]   a_sr, a_sr_nx;
    logic [OP_W-1:0]   b_sr, b_sr_nx;
    logic [OP_W-1:0]   res_sr, res_sr_nx;
    logic              borrow, borrow_nx;
    logic [CNT_W-1:0]  count, count_nx;
    logic [RES_W-1:0]  diff_q, diff_nx;
    logic              busy_q, busy_nx;
    logic              done_q, done_nx;
    logic              d_c;
    logic              borrow_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            borrow <= 1'b0;
            count  <= '0;
            diff_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            a_sr   <= a_sr_nx;
            b_sr   <= b_sr_nx;
            res_sr <= res_sr_nx;
            borrow <= borrow_nx;
            count  <= count_nx;
            diff_q <= diff_nx;
            busy_q <= busy_nx;
            done_q <= done_nx;
        end
    end

    // Full-subtractor cell on the current LSBs.
    always_comb begin
        d_c      = a_sr[0] ^ b_sr[0] ^ borrow;
        borrow_c = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow);
    end

    always_comb begin
        state_nx  = state;
        a_sr_nx   = a_sr;
        b_sr_nx   = b_sr;
        res_sr_nx = res_sr;
        borrow_nx = borrow;
        count_nx  = count;
        diff_nx   = diff_q;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    a_sr_nx   = bus.a;
                    b_sr_nx   = bus.b;
                    res_sr_nx = '0;
                    borrow_nx = 1'b0;
                    count_nx  = '0;
                    state_nx  = RUN;
                end
            end
            RUN: begin
                borrow_nx = borrow_c;
                res_sr_nx = {d_c, res_sr[OP_W-1:1]};
                a_sr_nx   = {1'b0, a_sr[OP_W-1:1]};
                b_sr_nx   = {1'b0, b_sr[OP_W-1:1]};
                count_nx  = count + CNT_W'(1);
                // Last bit: publish the whole result at once, never a partial one.
                if (count == CNT_W'(OP_W - 1)) begin
                    diff_nx  = {borrow_c, d_c, res_sr[OP_W-1:1]};
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        busy_nx = (state_nx == RUN);
        done_nx = (state_nx == DONE);
    end

    assign bus.diff = diff_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_serial_sub5.sv
// Self-checking bench for serial_sub5: directed cases plus random operands
// against an arithmetic reference model.
module tb_serial_sub5;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_pass;

    serial_sub5_if bus ();

    serial_sub5 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Reference subtractor: plain integer arithmetic reduced mod 64.
    function automatic logic [5:0] ref_sub(input logic [4:0] x, input logic [4:0] y);
        int d;
        d = int'(x) - int'(y);
        return d[5:0];
    endfunction

    // Companion combinational adder model used for the a - b + b == a cross-check.
    function automatic logic [5:0] adder5(input logic [4:0] x, input logic [4:0] y);
        int s;
        s = int'(x) + int'(y);
        return s[5:0];
    endfunction

    // Issue one operation and check handshake timing and result.
    task automatic do_op(input logic [4:0] av, input logic [4:0] bv, input string tag);
        int          busy_cnt;
        int          done_idx;
        int          overlap;
        logic [5:0]  got;
        logic [5:0]  exp;
        logic [5:0]  sum;
        exp      = ref_sub(av, bv);
        busy_cnt = 0;
        done_idx = 0;
        overlap  = 0;
        got      = '0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.a     = 5'(~av);
            bus.b     = 5'(~bv);
            if (bus.busy) busy_cnt++;
            if (bus.busy && bus.done) overlap++;
            if (bus.done && done_idx == 0) begin
                done_idx = k;
                got      = bus.diff;
            end
            if (done_idx != 0 && k > done_idx) break;
        end
        chk(32'(done_idx), 32'd6, {tag, "_latency"});
        chk(32'(busy_cnt), 32'd5, {tag, "_busy_cycles"});
        chk(32'(overlap), 32'd0, {tag, "_busy_done_overlap"});
        chk(32'(got), 32'(exp), {tag, "_diff"});
        chk(32'(got[5]), 32'(av < bv), {tag, "_sign"});
        sum = adder5(got[4:0], bv);
        chk(32'(sum[4:0]), 32'(av), {tag, "_adder_xcheck"});
        // Sampled one cycle after the done pulse: pulse gone, result held.
        chk(32'(bus.done), 32'd0, {tag, "_done_single"});
        chk(32'(bus.diff), 32'(exp), {tag, "_diff_hold"});
    endtask

    initial begin
        int done_cnt;
        int busy_cnt;
        int d1_idx;
        int d2_idx;
        logic [5:0] d1_val;
        logic [5:0] d2_val;
        logic [4:0] ra;
        logic [4:0] rb;

        n_chk     = 0;
        n_pass    = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        chk(32'(bus.diff), 32'd0, "reset_diff");
        chk(32'(bus.busy), 32'd0, "reset_busy");
        chk(32'(bus.done), 32'd0, "reset_done");

        // Reset wins over a simultaneous start.
        bus.start = 1'b1;
        bus.a     = 5'd7;
        bus.b     = 5'd3;
        @(negedge clk);
        chk(32'(bus.busy), 32'd0, "reset_beats_start");
        bus.start = 1'b0;
        reset     = 1'b0;

        do_op(5'd7,  5'd3,  "basic");
        repeat (3) @(negedge clk);
        chk(32'(bus.diff), 32'd4, "basic_diff_idle_hold");
        do_op(5'd3,  5'd5,  "negative");
        do_op(5'd31, 5'd31, "max_max");
        do_op(5'd0,  5'd31, "min_max");
        do_op(5'd31, 5'd0,  "max_min");
        do_op(5'd0,  5'd0,  "zero_zero");

        // Start held for 10 edges; operands change mid-RUN.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 5'd10;
        bus.b     = 5'd4;
        done_cnt  = 0;
        busy_cnt  = 0;
        d1_idx    = 0;
        d2_idx    = 0;
        d1_val    = '0;
        d2_val    = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 2) begin
                bus.a = 5'd1;
                bus.b = 5'd1;
            end
            if (k == 10) bus.start = 1'b0;
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (d1_idx == 0) begin
                    d1_idx = k;
                    d1_val = bus.diff;
                end else if (d2_idx == 0) begin
                    d2_idx = k;
                    d2_val = bus.diff;
                end
            end
        end
        chk(32'(d1_idx), 32'd6, "held_start_first_latency");
        chk(32'(d1_val), 32'd6, "held_start_first_diff");
        chk(32'(d2_idx), 32'd13, "held_start_second_done");
        chk(32'(d2_val), 32'd0, "held_start_second_diff");
        chk(32'(done_cnt), 32'd2, "held_start_done_count");
        chk(32'(busy_cnt), 32'd10, "held_start_busy_count");

        // Reset sampled at the third RUN edge aborts the operation.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 5'd20;
        bus.b     = 5'd9;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk(32'(bus.busy), 32'd0, "abort_busy");
        chk(32'(bus.done), 32'd0, "abort_done");
        chk(32'(bus.diff), 32'd0, "abort_diff");
        reset    = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy) done_cnt++;
        end
        chk(32'(done_cnt), 32'd0, "abort_no_done");
        do_op(5'd20, 5'd9, "after_abort");

        for (int i = 0; i < 1000; i++) begin
            ra = 5'($urandom_range(0, 31));
            rb = 5'($urandom_range(0, 31));
            do_op(ra, rb, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
